// File: rtl/tpu_instr_sequencer.sv
// Fetch/execute sequencer that replays a host-loaded program onto the TPU control pins.
// Each instruction takes one FETCH and one EXEC cycle. WAIT adds a programmable stall.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for seq_start_in; host may load the program
// S_FETCH | synchronous imem read at seq_pc
// S_EXEC  | decode the fetched word, update outputs, pick the next state
// S_STALL | WAIT down-counter running; leaves when the counter reaches 1
// S_DONE  | program finished (seq_error tells halt from fault)
module tpu_instr_sequencer #(
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_wr_en,
    input  logic [IMEM_AW-1:0] imem_wr_addr,
    input  logic [63:0]        imem_wr_data,
    input  logic               seq_start_in,
    input  logic               seq_abort_in,
    output logic               ub_rd_start_in,
    output logic               ub_rd_transpose,
    output logic [8:0]         ub_ptr_select,
    output logic [15:0]        ub_rd_addr_in,
    output logic [15:0]        ub_rd_row_size,
    output logic [15:0]        ub_rd_col_size,
    output logic [15:0]        learning_rate_in,
    output logic [15:0]        vpu_leak_factor_in,
    output logic [15:0]        inv_batch_size_times_two_in,
    output logic [3:0]         vpu_data_pathway,
    output logic [1:0]         sys_mode,
    output logic               sys_switch_in,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               seq_error,
    output logic [IMEM_AW-1:0] seq_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_STALL,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_UB_READ = 4'd1;
    localparam logic [3:0] OP_SET_CFG = 4'd2;
    localparam logic [3:0] OP_SWITCH  = 4'd3;
    localparam logic [3:0] OP_WAIT    = 4'd4;
    localparam logic [3:0] OP_HALT    = 4'd5;

    localparam logic [IMEM_AW-1:0] PC_LAST = IMEM_AW'(IMEM_DEPTH - 1);

    state_t      state;
    logic [63:0] imem [IMEM_DEPTH];
    logic [63:0] instr;
    logic [15:0] stall_cnt;

    logic [3:0]  opcode;
    logic [3:0]  cfg_sel;
    logic [15:0] imm;
    logic        op_illegal;
    logic        at_last;

    always_comb begin
        opcode     = instr[63:60];
        cfg_sel    = instr[59:56];
        imm        = instr[15:0];
        at_last    = (seq_pc == PC_LAST);
        op_illegal = 1'b0;
        if (opcode > OP_HALT) begin
            op_illegal = 1'b1;
        end else if (opcode == OP_SET_CFG && cfg_sel > 4'd3) begin
            op_illegal = 1'b1;
        end
    end

    // Program memory is left unreset so it maps onto a plain RAM.
    always_ff @(posedge clk) begin
        if (imem_wr_en && !seq_busy) begin
            imem[imem_wr_addr] <= imem_wr_data;
        end
        if (state == S_FETCH) begin
            instr <= imem[seq_pc];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                       <= S_IDLE;
            seq_pc                      <= '0;
            stall_cnt                   <= '0;
            seq_busy                    <= 1'b0;
            seq_done                    <= 1'b0;
            seq_error                   <= 1'b0;
            ub_rd_start_in              <= 1'b0;
            ub_rd_transpose             <= 1'b0;
            ub_ptr_select               <= '0;
            ub_rd_addr_in               <= '0;
            ub_rd_row_size              <= '0;
            ub_rd_col_size              <= '0;
            learning_rate_in            <= '0;
            vpu_leak_factor_in          <= '0;
            inv_batch_size_times_two_in <= '0;
            vpu_data_pathway            <= '0;
            sys_mode                    <= '0;
            sys_switch_in               <= 1'b0;
        end else begin
            ub_rd_start_in <= 1'b0;
            sys_switch_in  <= 1'b0;
            if (seq_abort_in) begin
                state     <= S_IDLE;
                seq_pc    <= '0;
                stall_cnt <= '0;
                seq_busy  <= 1'b0;
                seq_done  <= 1'b0;
                seq_error <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (seq_start_in) begin
                            state     <= S_FETCH;
                            seq_pc    <= '0;
                            seq_busy  <= 1'b1;
                            seq_done  <= 1'b0;
                            seq_error <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        state <= S_EXEC;
                    end
                    S_EXEC: begin
                        case (opcode)
                            OP_UB_READ: begin
                                ub_rd_start_in  <= 1'b1;
                                ub_rd_transpose <= instr[59];
                                ub_ptr_select   <= instr[58:50];
                                ub_rd_addr_in   <= instr[49:34];
                                ub_rd_row_size  <= instr[33:18];
                                ub_rd_col_size  <= instr[17:2];
                            end
                            OP_SET_CFG: begin
                                case (cfg_sel)
                                    4'd0: learning_rate_in            <= imm;
                                    4'd1: vpu_leak_factor_in          <= imm;
                                    4'd2: inv_batch_size_times_two_in <= imm;
                                    4'd3: begin
                                        vpu_data_pathway <= imm[3:0];
                                        sys_mode         <= imm[5:4];
                                    end
                                    default: ;
                                endcase
                            end
                            OP_SWITCH: sys_switch_in <= 1'b1;
                            default: ;
                        endcase

                        if (opcode == OP_HALT) begin
                            state    <= S_DONE;
                            seq_busy <= 1'b0;
                            seq_done <= 1'b1;
                        end else if (op_illegal) begin
                            state     <= S_DONE;
                            seq_busy  <= 1'b0;
                            seq_done  <= 1'b1;
                            seq_error <= 1'b1;
                        end else if (opcode == OP_WAIT && imm != 16'd0) begin
                            state     <= S_STALL;
                            stall_cnt <= imm;
                        end else if (at_last) begin
                            // Running off the end of memory is a fault, never a wrap.
                            state     <= S_DONE;
                            seq_busy  <= 1'b0;
                            seq_done  <= 1'b1;
                            seq_error <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            seq_pc <= seq_pc + IMEM_AW'(1);
                        end
                    end
                    S_STALL: begin
                        if (stall_cnt == 16'd1) begin
                            if (at_last) begin
                                state     <= S_DONE;
                                seq_busy  <= 1'b0;
                                seq_done  <= 1'b1;
                                seq_error <= 1'b1;
                            end else begin
                                state  <= S_FETCH;
                                seq_pc <= seq_pc + IMEM_AW'(1);
                            end
                        end else begin
                            stall_cnt <= stall_cnt - 16'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Directed bench for tpu_instr_sequencer: a vector table of single-instruction
// programs plus hand-written multi-cycle sequences (timing, WAIT, faults, abort).
module tb_tpu_instr_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [63:0]   imem_wr_data;
    logic          seq_start_in;
    logic          seq_abort_in;
    logic          ub_rd_start_in;
    logic          ub_rd_transpose;
    logic [8:0]    ub_ptr_select;
    logic [15:0]   ub_rd_addr_in;
    logic [15:0]   ub_rd_row_size;
    logic [15:0]   ub_rd_col_size;
    logic [15:0]   learning_rate_in;
    logic [15:0]   vpu_leak_factor_in;
    logic [15:0]   inv_batch_size_times_two_in;
    logic [3:0]    vpu_data_pathway;
    logic [1:0]    sys_mode;
    logic          sys_switch_in;
    logic          seq_busy;
    logic          seq_done;
    logic          seq_error;
    logic [AW-1:0] seq_pc;

    tpu_instr_sequencer #(.IMEM_DEPTH(DEPTH)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .imem_wr_en                  (imem_wr_en),
        .imem_wr_addr                (imem_wr_addr),
        .imem_wr_data                (imem_wr_data),
        .seq_start_in                (seq_start_in),
        .seq_abort_in                (seq_abort_in),
        .ub_rd_start_in              (ub_rd_start_in),
        .ub_rd_transpose             (ub_rd_transpose),
        .ub_ptr_select               (ub_ptr_select),
        .ub_rd_addr_in               (ub_rd_addr_in),
        .ub_rd_row_size              (ub_rd_row_size),
        .ub_rd_col_size              (ub_rd_col_size),
        .learning_rate_in            (learning_rate_in),
        .vpu_leak_factor_in          (vpu_leak_factor_in),
        .inv_batch_size_times_two_in (inv_batch_size_times_two_in),
        .vpu_data_pathway            (vpu_data_pathway),
        .sys_mode                    (sys_mode),
        .sys_switch_in               (sys_switch_in),
        .seq_busy                    (seq_busy),
        .seq_done                    (seq_done),
        .seq_error                   (seq_error),
        .seq_pc                      (seq_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] op(input logic [3:0] o);
        return {o, 60'h0};
    endfunction
    function automatic logic [63:0] op_set(input logic [3:0] sel, input logic [15:0] v);
        return {4'h2, sel, 40'h0, v};
    endfunction
    function automatic logic [63:0] op_ub(input logic t, input logic [8:0] p, input logic [15:0] a,
                                          input logic [15:0] r, input logic [15:0] c);
        return {4'h1, t, p, a, r, c, 2'b00};
    endfunction
    function automatic logic [63:0] op_wait(input logic [15:0] n);
        return {4'h4, 44'h0, n};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [63:0] d);
        imem_wr_en   = 1'b1;
        imem_wr_addr = a;
        imem_wr_data = d;
        tick();
        imem_wr_en   = 1'b0;
    endtask

    task automatic load4(input logic [63:0] i0, input logic [63:0] i1,
                         input logic [63:0] i2, input logic [63:0] i3);
        wr(2'd0, i0);
        wr(2'd1, i1);
        wr(2'd2, i2);
        wr(2'd3, i3);
    endtask

    task automatic do_start();
        seq_start_in = 1'b1;
        tick();
        seq_start_in = 1'b0;
    endtask

    // Pulse bookkeeping; cycle k means "sampled just after the k-th edge past the start edge".
    int          cyc, ub_n, ub_c0, ub_c1, sw_n, sw_c0, sw_c1;
    logic [57:0] ub_first, ub_last;

    task automatic run_prog(input int max);
        cyc = 0; ub_n = 0; ub_c0 = -1; ub_c1 = -1; sw_n = 0; sw_c0 = -1; sw_c1 = -1;
        do_start();
        while (!seq_done && cyc < max) begin
            tick();
            cyc++;
            if (ub_rd_start_in) begin
                if (ub_n == 0) ub_c0 = cyc;
                ub_c1 = cyc;
                ub_n++;
                ub_last = {ub_rd_transpose, ub_ptr_select, ub_rd_addr_in, ub_rd_row_size, ub_rd_col_size};
                if (ub_n == 1) ub_first = ub_last;
            end
            if (sys_switch_in) begin
                if (sw_n == 0) sw_c0 = cyc;
                sw_c1 = cyc;
                sw_n++;
            end
        end
    endtask

    typedef struct {
        logic [63:0] instr;
        logic [15:0] lr, leak, inv;
        logic [3:0]  path;
        logic [1:0]  mode;
        logic        err;
        logic [1:0]  pc;
        int          done_cyc;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Expected register state accumulates down the table: config registers hold between runs.
        tbl[0] = '{op_set(4'd0, 16'h1234), 16'h1234, 16'h0000, 16'h0000, 4'h0, 2'd0, 1'b0, 2'd1, 4};
        tbl[1] = '{op_set(4'd1, 16'hBEEF), 16'h1234, 16'hBEEF, 16'h0000, 4'h0, 2'd0, 1'b0, 2'd1, 4};
        tbl[2] = '{op_set(4'd2, 16'h0080), 16'h1234, 16'hBEEF, 16'h0080, 4'h0, 2'd0, 1'b0, 2'd1, 4};
        tbl[3] = '{op_set(4'd3, 16'hFFF7), 16'h1234, 16'hBEEF, 16'h0080, 4'h7, 2'd3, 1'b0, 2'd1, 4};
        tbl[4] = '{op_set(4'd4, 16'h5555), 16'h1234, 16'hBEEF, 16'h0080, 4'h7, 2'd3, 1'b1, 2'd0, 2};
        tbl[5] = '{op(4'h6),               16'h1234, 16'hBEEF, 16'h0080, 4'h7, 2'd3, 1'b1, 2'd0, 2};
        tbl[6] = '{op(4'h0),               16'h1234, 16'hBEEF, 16'h0080, 4'h7, 2'd3, 1'b0, 2'd1, 4};
        tbl[7] = '{op_set(4'd0, 16'h0000), 16'h0000, 16'hBEEF, 16'h0080, 4'h7, 2'd3, 1'b0, 2'd1, 4};

        // Reset with random inputs
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_wr_en   = 1'($urandom);
            imem_wr_addr = 2'($urandom);
            imem_wr_data = {$urandom, $urandom};
            seq_start_in = 1'($urandom);
            seq_abort_in = 1'($urandom);
            tick();
        end
        check("rst_cfg", {learning_rate_in, vpu_leak_factor_in, inv_batch_size_times_two_in,
                          vpu_data_pathway, sys_mode}, 64'h0);
        check("rst_ub", {ub_rd_transpose, ub_ptr_select, ub_rd_addr_in, ub_rd_row_size, ub_rd_col_size}, 64'h0);
        check("rst_pulses", {ub_rd_start_in, sys_switch_in}, 64'h0);
        check("rst_status", {seq_busy, seq_done, seq_error}, 64'h0);
        check("rst_pc", seq_pc, 64'h0);
        imem_wr_en = 1'b0; seq_start_in = 1'b0; seq_abort_in = 1'b0;
        rst = 1'b1;
        tick();

        // Vector table: each entry is {instr, HALT}
        for (int i = 0; i < 8; i++) begin
            wr(2'd0, tbl[i].instr);
            wr(2'd1, op(4'h5));
            run_prog(20);
            check($sformatf("tbl%0d_done", i), seq_done, 1);
            check($sformatf("tbl%0d_cyc", i), cyc, tbl[i].done_cyc);
            check($sformatf("tbl%0d_err", i), seq_error, tbl[i].err);
            check($sformatf("tbl%0d_pc", i), seq_pc, tbl[i].pc);
            check($sformatf("tbl%0d_cfg", i),
                  {learning_rate_in, vpu_leak_factor_in, inv_batch_size_times_two_in, vpu_data_pathway, sys_mode},
                  {tbl[i].lr, tbl[i].leak, tbl[i].inv, tbl[i].path, tbl[i].mode});
        end

        // Main program: done 8 cycles after start, UB pulse in instruction 2's result cycle
        load4(op_set(4'd0, 16'h3C00), op_set(4'd3, 16'h0021), op_ub(1'b1, 9'd5, 16'h0010, 16'd4, 16'd2), op(4'h5));
        seq_start_in = 1'b1;
        tick();
        seq_start_in = 1'b0;
        check("main_busy", seq_busy, 1);
        cyc = 0; ub_n = 0; ub_c0 = -1; ub_c1 = -1; sw_n = 0;
        while (!seq_done && cyc < 20) begin
            tick();
            cyc++;
            if (ub_rd_start_in) begin
                if (ub_n == 0) ub_c0 = cyc;
                ub_n++;
                ub_first = {ub_rd_transpose, ub_ptr_select, ub_rd_addr_in, ub_rd_row_size, ub_rd_col_size};
            end
        end
        check("main_done_cyc", cyc, 8);
        check("main_status", {seq_done, seq_error, seq_busy}, 3'b100);
        check("main_lr", learning_rate_in, 16'h3C00);
        check("main_path_mode", {vpu_data_pathway, sys_mode}, {4'h1, 2'd2});
        check("main_ub_n", ub_n, 1);
        check("main_ub_cyc", ub_c0, 6);
        check("main_ub_fields", ub_first, {1'b1, 9'd5, 16'h0010, 16'd4, 16'd2});

        // Back-to-back UB_READs two cycles apart, fields held after the pulse
        load4(op_ub(1'b0, 9'h1FF, 16'hFFFF, 16'h0001, 16'h8000), op_ub(1'b1, 9'd3, 16'h1234, 16'd7, 16'd9),
              op(4'h5), op(4'h0));
        run_prog(20);
        check("b2b_ub_n", ub_n, 2);
        check("b2b_ub_gap", ub_c1 - ub_c0, 2);
        check("b2b_first", ub_first, {1'b0, 9'h1FF, 16'hFFFF, 16'h0001, 16'h8000});
        check("b2b_last", ub_last, {1'b1, 9'd3, 16'h1234, 16'd7, 16'd9});
        check("b2b_hold", {ub_rd_start_in, ub_rd_transpose, ub_ptr_select, ub_rd_addr_in},
              {1'b0, 1'b1, 9'd3, 16'h1234});

        // SWITCH, WAIT 5, SWITCH: SWITCH(2) + WAIT(2) + stall(5) between rises
        load4(op(4'h3), op_wait(16'd5), op(4'h3), op(4'h5));
        run_prog(40);
        check("sw_n", sw_n, 2);
        check("sw_first", sw_c0, 2);
        check("sw_gap", sw_c1 - sw_c0, 9);
        check("sw_done_cyc", cyc, 13);
        check("sw_err", seq_error, 0);

        // Illegal opcode at pc 2 stops everything
        load4(op_set(4'd1, 16'h1111), op(4'h0), op(4'hF), op_set(4'd0, 16'h9999));
        run_prog(20);
        check("ill_done_cyc", cyc, 6);
        check("ill_status", {seq_done, seq_error, seq_busy}, 3'b110);
        check("ill_pc", seq_pc, 2);
        check("ill_cfg", {learning_rate_in, vpu_leak_factor_in}, {16'h3C00, 16'h1111});
        repeat (3) tick();
        check("ill_hold", {seq_done, seq_error, seq_pc, learning_rate_in, ub_rd_start_in, sys_switch_in},
              {1'b1, 1'b1, 2'd2, 16'h3C00, 1'b0, 1'b0});

        // All NOPs: end of memory is a fault
        load4(op(4'h0), op(4'h0), op(4'h0), op(4'h0));
        run_prog(20);
        check("eom_done_cyc", cyc, 8);
        check("eom_status", {seq_done, seq_error}, 2'b11);
        check("eom_pc", seq_pc, 3);

        // Abort during WAIT 100
        load4(op_set(4'd2, 16'h0042), op_wait(16'd100), op(4'h5), op(4'h0));
        do_start();
        repeat (10) tick();
        check("abt_in_stall", {seq_busy, seq_pc}, {1'b1, 2'd1});
        seq_abort_in = 1'b1;
        tick();
        seq_abort_in = 1'b0;
        check("abt_status", {seq_busy, seq_done, seq_error, seq_pc}, {3'b000, 2'd0});
        check("abt_cfg", {inv_batch_size_times_two_in, learning_rate_in, vpu_leak_factor_in},
              {16'h0042, 16'h3C00, 16'h1111});

        // Rerun with a host write and a start while busy; both must be ignored
        do_start();
        cyc = 0;
        while (!seq_done && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 5) begin
                imem_wr_en = 1'b1; imem_wr_addr = 2'd0; imem_wr_data = op_set(4'd2, 16'h0055);
            end else if (cyc == 6) begin
                imem_wr_en = 1'b0; seq_start_in = 1'b1;
            end else if (cyc == 7) begin
                seq_start_in = 1'b0;
            end
        end
        check("busy_start_cyc", cyc, 106);
        check("busy_start_pc", seq_pc, 2);

        run_prog(200);
        check("wr_drop_cyc", cyc, 106);
        check("wr_drop_inv", inv_batch_size_times_two_in, 16'h0042);

        // Abort beats start in the same cycle
        seq_abort_in = 1'b1; seq_start_in = 1'b1;
        tick();
        seq_abort_in = 1'b0; seq_start_in = 1'b0;
        check("abt_vs_start", {seq_busy, seq_done}, 2'b00);
        tick();
        check("abt_vs_start_idle", seq_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
